vga_scan_controller: RTL

- Downstream consumer of the 80x60 1-bit frame buffer; generates 640x480@60 Hz VGA timing for the DE10-Lite DAC.
- Issues frame-buffer read coordinates (pixel/8 scaling), absorbs the buffer's 1-clk registered read latency, and drives 4-bit RGB plus sync aligned to each other.
- Also gives upstream logic a start-of-vblank strobe, marking a safe window for clear and bulk writes.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_timing_counter.sv | 62 ++++++
 rtl/vga_scan_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, frame-buffer geometry and colours
// used by vga_scan_controller and its timing counter.
package vga_timing_pkg;

  localparam int CLK_DIV     = 2;
  localparam int H_VISIBLE   = 640;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int V_VISIBLE   = 480;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int SCALE_SHIFT = 3;

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam int CNT_W = 10;

  localparam int         FB_COLS = 80;
  localparam int         FB_ROWS = 60;
  localparam logic [6:0] OOR_X   = 7'd127;
  localparam logic [5:0] OOR_Y   = 6'd63;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COLOUR_WHITE = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t COLOUR_BLACK = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam rgb_t CURSOR_RED   = '{r: 4'hF, g: 4'h0, b: 4'h0};

endpackage

// File: rtl/vga_timing_counter.sv
// Pixel-clock divider plus horizontal/vertical scan counters; all counter
// movement is gated by pix_tick.
module vga_timing_counter #(
  parameter int CLK_DIV   = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_TOTAL   = vga_timing_pkg::H_TOTAL,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_TOTAL   = vga_timing_pkg::V_TOTAL
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             pix_tick,
  output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
  output logic [vga_timing_pkg::CNT_W-1:0] v_cnt,
  output logic                             visible
);
  import vga_timing_pkg::CNT_W;

  localparam int                DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0]  V_VIS    = CNT_W'(V_VISIBLE);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [CNT_W-1:0] v_q, v_d;

  assign pix_tick = (div_q == DIV_LAST);
  assign h_cnt    = h_q;
  assign v_cnt    = v_q;
  assign visible  = (h_q < H_VIS) && (v_q < V_VIS);

  always_comb begin
    div_d = div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

endmodule

// File: rtl/vga_scan_controller.sv
// VGA scan-out of the 80x60 1-bit frame buffer: read-address mapping, one-pixel
// output register for RGB/sync, vblank strobe. CURSOR_OVERLAY_EN adds a red cursor box.
module vga_scan_controller #(
  parameter int CLK_DIV     = vga_timing_pkg::CLK_DIV,
  parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter int SCALE_SHIFT = vga_timing_pkg::SCALE_SHIFT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fb_pixel,
  output logic [6:0] x_coordinate_of_pixel_to_read,
  output logic [5:0] y_coordinate_of_pixel_to_read,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vblank_start
`ifdef CURSOR_OVERLAY_EN
  ,
  input  logic [6:0] cursor_x,
  input  logic [5:0] cursor_y
`endif
);
  import vga_timing_pkg::CNT_W;
  import vga_timing_pkg::OOR_X;
  import vga_timing_pkg::OOR_Y;
  import vga_timing_pkg::rgb_t;
  import vga_timing_pkg::COLOUR_WHITE;
  import vga_timing_pkg::COLOUR_BLACK;
  import vga_timing_pkg::CURSOR_RED;

  localparam int H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);

  logic             pix_tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             visible;
  logic [6:0]       cell_x;
  logic [5:0]       cell_y;

  rgb_t rgb_q, rgb_d;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic vblank_q, vblank_d;

  vga_timing_counter #(
    .CLK_DIV  (CLK_DIV),
    .H_VISIBLE(H_VISIBLE),
    .H_TOTAL  (H_TOT),
    .V_VISIBLE(V_VISIBLE),
    .V_TOTAL  (V_TOT)
  ) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_tick(pix_tick),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .visible (visible)
  );

  // Address held for a whole pixel, so the buffer's registered data lands by the next tick.
  assign cell_x = 7'(h_cnt >> SCALE_SHIFT);
  assign cell_y = 6'(v_cnt >> SCALE_SHIFT);
  assign x_coordinate_of_pixel_to_read = visible ? cell_x : OOR_X;
  assign y_coordinate_of_pixel_to_read = visible ? cell_y : OOR_Y;

`ifdef CURSOR_OVERLAY_EN
  logic [SCALE_SHIFT-1:0] h_off;
  logic [SCALE_SHIFT-1:0] v_off;
  logic                   cursor_hit;

  assign h_off      = h_cnt[SCALE_SHIFT-1:0];
  assign v_off      = v_cnt[SCALE_SHIFT-1:0];
  assign cursor_hit = visible && (cell_x == cursor_x) && (cell_y == cursor_y) &&
                      ((h_off == '0) || (h_off == '1) || (v_off == '0) || (v_off == '1));
`endif

  always_comb begin
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    vblank_d = 1'b0;
    if (pix_tick) begin
      if (!visible || fb_pixel) rgb_d = COLOUR_BLACK;
      else                      rgb_d = COLOUR_WHITE;
`ifdef CURSOR_OVERLAY_EN
      if (cursor_hit) rgb_d = CURSOR_RED;
`endif
      hs_d     = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
      vs_d     = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
      vblank_d = (h_cnt == H_LAST) && (v_cnt == V_VIS_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q    <= COLOUR_BLACK;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vblank_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      vblank_q <= vblank_d;
    end
  end

  assign vga_r        = rgb_q.r;
  assign vga_g        = rgb_q.g;
  assign vga_b        = rgb_q.b;
  assign vga_hs       = hs_q;
  assign vga_vs       = vs_q;
  assign vblank_start = vblank_q;

endmodule
